// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin binary-index arbiter.
package arb_pkg;

    localparam int NUM_REQ_DEF = 16;
    localparam int BIN_W_DEF   = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    typedef logic [BIN_W_DEF-1:0] gnt_idx_t;

endpackage : arb_pkg

// File: rtl/rr_arbiter_bin_pick.sv
// Rotated priority encoder: lowest set request at or above ptr, else the
// lowest set request overall. Purely combinational.
module rr_pick
    import arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int BIN_W   = BIN_W_DEF
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [BIN_W-1:0]   ptr,
    output logic               found,
    output logic [BIN_W-1:0]   idx
);

    logic [NUM_REQ-1:0] w_masked;
    logic               w_hi_found;
    logic [BIN_W-1:0]   w_hi_idx;
    logic               w_lo_found;
    logic [BIN_W-1:0]   w_lo_idx;

    // Keep only requests whose index is at or above the pointer.
    always_comb begin
        w_masked = {NUM_REQ{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            w_masked[i] = req[i] & (BIN_W'(i) >= ptr);
        end
    end

    // Lowest-index encode of the masked vector (scan downward so the lowest wins).
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_idx   = {BIN_W{1'b0}};
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_hi_found = w_masked[i] ? 1'b1       : w_hi_found;
            w_hi_idx   = w_masked[i] ? BIN_W'(i)  : w_hi_idx;
        end
    end

    // Lowest-index encode of the full vector, used when nothing sits above ptr.
    always_comb begin
        w_lo_found = 1'b0;
        w_lo_idx   = {BIN_W{1'b0}};
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_lo_found = req[i] ? 1'b1      : w_lo_found;
            w_lo_idx   = req[i] ? BIN_W'(i) : w_lo_idx;
        end
    end

    // Prefer the upper (non-wrapped) winner; fall back to the wrapped search.
    always_comb begin
        if (w_hi_found) begin
            found = 1'b1;
            idx   = w_hi_idx;
        end else begin
            found = w_lo_found;
            idx   = w_lo_idx;
        end
    end

endmodule : rr_pick

// File: rtl/rr_arbiter_bin.sv
// Round-robin arbiter emitting a registered binary grant index with a
// valid/ready handshake. The priority pointer moves one past each accepted
// grant so the accepted requester drops to lowest priority.
module rr_arbiter_bin
    import arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int BIN_W   = BIN_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               gnt_ready_i,
    output logic               gnt_valid_o,
    output logic [BIN_W-1:0]   gnt_bin_o
);

    arb_state_e         r_state;
    logic [BIN_W-1:0]   r_ptr;
    logic [BIN_W-1:0]   r_gnt_bin;
    logic               r_gnt_valid;

    logic [BIN_W-1:0]   w_ptr_inc;
    logic [BIN_W-1:0]   w_pick_ptr;
    logic               w_found;
    logic [BIN_W-1:0]   w_idx;

    // Pointer one past the current grant, wrapping at NUM_REQ-1 so a
    // non-power-of-two requester count never yields an out-of-range pointer.
    always_comb begin
        if (r_gnt_bin == BIN_W'(NUM_REQ - 1)) begin
            w_ptr_inc = {BIN_W{1'b0}};
        end else begin
            w_ptr_inc = r_gnt_bin + BIN_W'(1);
        end
    end

    // In GRANT the only re-arbitration happens on a handshake, and it must
    // already see the advanced pointer; in IDLE the stored pointer is used.
    always_comb begin
        case (r_state)
            IDLE:    w_pick_ptr = r_ptr;
            GRANT:   w_pick_ptr = w_ptr_inc;
            default: w_pick_ptr = r_ptr;
        endcase
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .BIN_W   (BIN_W)
    ) u_pick (
        .req   (req_i),
        .ptr   (w_pick_ptr),
        .found (w_found),
        .idx   (w_idx)
    );

    // Grant FSM with pointer and registered outputs; reset drops any grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_ptr       <= {BIN_W{1'b0}};
            r_gnt_bin   <= {BIN_W{1'b0}};
            r_gnt_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_gnt_bin   <= w_idx;
                        r_gnt_valid <= 1'b1;
                        r_state     <= GRANT;
                    end else begin
                        r_gnt_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                GRANT: begin
                    if (gnt_ready_i) begin
                        r_ptr <= w_ptr_inc;
                        if (w_found) begin
                            r_gnt_bin   <= w_idx;
                            r_gnt_valid <= 1'b1;
                            r_state     <= GRANT;
                        end else begin
                            r_gnt_valid <= 1'b0;
                            r_state     <= IDLE;
                        end
                    end else begin
                        r_gnt_valid <= 1'b1;
                        r_state     <= GRANT;
                    end
                end
                default: begin
                    r_gnt_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign gnt_valid_o = r_gnt_valid;
    assign gnt_bin_o   = r_gnt_bin;

endmodule : rr_arbiter_bin

// File: tb/tb_rr_arbiter_bin.sv
// Self-checking bench for rr_arbiter_bin: directed vector table plus a
// random integration phase checked against a behavioural round-robin model.
module tb_rr_arbiter_bin;
    import arb_pkg::*;

    localparam int N = 16;

    logic          clk;
    logic          reset;
    logic [N-1:0]  req_i;
    logic          gnt_ready_i;
    logic          gnt_valid_o;
    gnt_idx_t      gnt_bin_o;
    logic [N-1:0]  w_dec;

    int total;
    int bad;

    rr_arbiter_bin #(.NUM_REQ(N), .BIN_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_i       (req_i),
        .gnt_ready_i (gnt_ready_i),
        .gnt_valid_o (gnt_valid_o),
        .gnt_bin_o   (gnt_bin_o)
    );

    // Downstream binary-to-one-hot decoder.
    assign w_dec = 16'h0001 << gnt_bin_o;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [15:0] req;
        logic        rdy;
        logic        ev;
        int          eb;
        logic        cb;
    } vec_t;

    typedef struct {
        logic ev;
        int   eb;
        logic cb;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    // Behavioural reference model state.
    logic m_valid;
    int   m_bin;
    int   m_ptr;

    function automatic vec_t mkv(logic rst, logic [15:0] req, logic rdy,
                                 logic ev, int eb, logic cb);
        vec_t v;
        v.rst = rst; v.req = req; v.rdy = rdy; v.ev = ev; v.eb = eb; v.cb = cb;
        return v;
    endfunction

    function automatic int rr_search(logic [15:0] r, int p);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (p + k) % N;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_step(input logic rst, input logic [15:0] r, input logic rdy);
        int w;
        if (rst) begin
            m_valid = 1'b0; m_bin = 0; m_ptr = 0;
        end else if (!m_valid) begin
            w = rr_search(r, m_ptr);
            if (w >= 0) begin m_valid = 1'b1; m_bin = w; end
        end else if (rdy) begin
            m_ptr = (m_bin + 1) % N;
            w = rr_search(r, m_ptr);
            if (w >= 0) m_bin = w;
            else m_valid = 1'b0;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive at the falling edge, push expectation, compare after
    // the next falling edge (outputs registered on the rising edge between).
    task automatic cyc(input logic rst, input logic [15:0] r, input logic rdy,
                       input logic use_model, input exp_t tab, input string name);
        exp_t e;
        exp_t got;
        reset = rst; req_i = r; gnt_ready_i = rdy;
        model_step(rst, r, rdy);
        if (use_model) begin
            e.ev = m_valid; e.eb = m_bin; e.cb = m_valid;
        end else begin
            e = tab;
        end
        sb.push_back(e);
        @(negedge clk);
        got = sb.pop_front();
        check({name, "_valid"}, int'(gnt_valid_o), int'(got.ev));
        if (got.cb) check({name, "_bin"}, int'(gnt_bin_o), got.eb);
    endtask

    initial begin
        exp_t dummy;
        int   wait_cnt[N];
        logic pre_v;
        int   pre_b;
        logic acc;
        int   gidx;
        logic [15:0] r;
        logic rdy;
        int   hold;

        total = 0; bad = 0;
        reset = 1'b1; req_i = 16'h0000; gnt_ready_i = 1'b0;
        m_valid = 1'b0; m_bin = 0; m_ptr = 0;
        dummy.ev = 1'b0; dummy.eb = 0; dummy.cb = 1'b0;

        // Reset, idle ignores ready, latency, pointer advanced to 1.
        vecs.push_back(mkv(1'b1, 16'h0000, 1'b0, 1'b0, 0,  1'b1));
        vecs.push_back(mkv(1'b0, 16'h0000, 1'b1, 1'b0, 0,  1'b0));
        vecs.push_back(mkv(1'b0, 16'h0001, 1'b1, 1'b1, 0,  1'b1));
        vecs.push_back(mkv(1'b0, 16'h0000, 1'b1, 1'b0, 0,  1'b0));
        vecs.push_back(mkv(1'b0, 16'h0003, 1'b0, 1'b1, 1,  1'b1));
        vecs.push_back(mkv(1'b1, 16'h0003, 1'b1, 1'b0, 0,  1'b1));
        // Rotation over 16'h8421.
        vecs.push_back(mkv(1'b0, 16'h8421, 1'b1, 1'b1, 0,  1'b1));
        vecs.push_back(mkv(1'b0, 16'h8421, 1'b1, 1'b1, 5,  1'b1));
        vecs.push_back(mkv(1'b0, 16'h8421, 1'b1, 1'b1, 10, 1'b1));
        vecs.push_back(mkv(1'b0, 16'h8421, 1'b1, 1'b1, 15, 1'b1));
        vecs.push_back(mkv(1'b0, 16'h8421, 1'b1, 1'b1, 0,  1'b1));
        vecs.push_back(mkv(1'b0, 16'h8421, 1'b1, 1'b1, 5,  1'b1));
        // Wrap-around: grant 14, then C003 gives 15, 0, 1, 14.
        vecs.push_back(mkv(1'b1, 16'h0000, 1'b0, 1'b0, 0,  1'b1));
        vecs.push_back(mkv(1'b0, 16'h4000, 1'b1, 1'b1, 14, 1'b1));
        vecs.push_back(mkv(1'b0, 16'hC003, 1'b1, 1'b1, 15, 1'b1));
        vecs.push_back(mkv(1'b0, 16'hC003, 1'b1, 1'b1, 0,  1'b1));
        vecs.push_back(mkv(1'b0, 16'hC003, 1'b1, 1'b1, 1,  1'b1));
        vecs.push_back(mkv(1'b0, 16'hC003, 1'b1, 1'b1, 14, 1'b1));
        // Backpressure: grant 3 held while requests change, then 8, then idle.
        vecs.push_back(mkv(1'b1, 16'h0000, 1'b0, 1'b0, 0,  1'b1));
        vecs.push_back(mkv(1'b0, 16'h0008, 1'b1, 1'b1, 3,  1'b1));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mkv(1'b0, 16'h0100, 1'b0, 1'b1, 3, 1'b1));
        vecs.push_back(mkv(1'b0, 16'h0100, 1'b1, 1'b1, 8,  1'b1));
        vecs.push_back(mkv(1'b0, 16'h0000, 1'b1, 1'b0, 0,  1'b0));
        // Reset mid-grant drops grant 7; pointer returns to 0.
        vecs.push_back(mkv(1'b1, 16'h0000, 1'b0, 1'b0, 0,  1'b1));
        vecs.push_back(mkv(1'b0, 16'h0080, 1'b1, 1'b1, 7,  1'b1));
        vecs.push_back(mkv(1'b0, 16'h0080, 1'b0, 1'b1, 7,  1'b1));
        vecs.push_back(mkv(1'b1, 16'h0080, 1'b0, 1'b0, 0,  1'b1));
        vecs.push_back(mkv(1'b0, 16'h0081, 1'b1, 1'b1, 0,  1'b1));

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            exp_t e;
            e.ev = vecs[i].ev; e.eb = vecs[i].eb; e.cb = vecs[i].cb;
            cyc(vecs[i].rst, vecs[i].req, vecs[i].rdy, 1'b0, e, $sformatf("vec%0d", i));
        end

        // Integration: random requests and ready against the model.
        cyc(1'b1, 16'h0000, 1'b0, 1'b1, dummy, "rnd_reset");
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        for (int v = 0; v < 32; v++) begin
            r = 16'($urandom);
            hold = $urandom_range(1, 4);
            for (int h = 0; h < hold; h++) begin
                rdy   = ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0;
                pre_v = gnt_valid_o;
                pre_b = int'(gnt_bin_o);
                acc   = m_valid && rdy;
                gidx  = m_bin;
                cyc(1'b0, r, rdy, 1'b1, dummy, "rnd");
                if (gnt_valid_o)
                    check("decode", int'(w_dec), int'(16'h0001 << m_bin));
                if (pre_v && !rdy)
                    check("hold", int'(gnt_bin_o), pre_b);
                for (int i = 0; i < N; i++) begin
                    if (!r[i]) wait_cnt[i] = 0;
                    else if (acc && i == gidx) wait_cnt[i] = 0;
                    else if (acc) wait_cnt[i]++;
                    if (acc && r[i])
                        check($sformatf("starve%0d", i), int'(wait_cnt[i] <= N), 1);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_rr_arbiter_bin

// File: doc/rr_arbiter_bin.md
# rr_arbiter_bin

Round-robin arbiter over `NUM_REQ` requesters that emits the winning requester as a registered binary index with a valid/ready handshake. It sits directly upstream of the binary-to-one-hot decoder: `gnt_bin_o` drives the decoder's `bin_i`, and the decoder's output becomes the one-hot grant/select bus. Fairness comes from a rotating priority pointer that advances past each accepted grant.

## Interface
- `NUM_REQ`, default 16: number of requesters; must be ≥2.
- `BIN_W`, default 4: index width, equal to `$clog2(NUM_REQ)`; must match the decoder's `BIN_W`.
- `clk`  input  1: single clock; all state updates on the rising edge.
- `reset`  input  1: synchronous, active-high reset.
- `req_i`  input  NUM_REQ: request vector, one bit per requester; level-sensitive.
- `gnt_ready_i`  input  1: downstream accepts the current grant.
- `gnt_valid_o`  output  1: `gnt_bin_o` holds a valid grant.
- `gnt_bin_o`  output  BIN_W: binary index of the granted requester.

## Operation
- State machine with two states.
  - IDLE: `gnt_valid_o`=0. Arbitrates every cycle. If any `req_i` bit is set, registers the winner and moves to GRANT; otherwise stays in IDLE.
  - GRANT: `gnt_valid_o`=1. The grant is held stable until a handshake.
    - On handshake (`gnt_ready_i`=1): pointer ← (`gnt_bin_o`+1) mod `NUM_REQ`. Arbitration is then re-run in the same cycle, starting from the new pointer value and using the current `req_i`.
    - If the re-run finds a winner: register it and stay in GRANT.
    - If it finds none: go to IDLE.
- Arbitration rule: the winner is the lowest index i ≥ pointer with `req_i[i]`=1. If there is none, the search wraps and takes the lowest index i < pointer with `req_i[i]`=1.
- Pointer arithmetic is modulo `NUM_REQ`.
  - `NUM_REQ`-1 wraps to 0.
  - For non-power-of-two `NUM_REQ`, the pointer never holds a value ≥ `NUM_REQ`.
- Grant stability: while `gnt_valid_o`=1 and `gnt_ready_i`=0, `gnt_bin_o` must not change. This holds even if the granted requester drops its `req_i` bit; the grant stays until accepted.
- A requester that keeps its request asserted after acceptance is eligible again, but only at the lowest priority for the next arbitration.
- `gnt_ready_i` is ignored in IDLE.

## Timing
- Reset: `gnt_valid_o`=0, `gnt_bin_o`=0, pointer=0, state IDLE. Reset overrides all other inputs, including a reset that arrives mid-grant; the in-flight grant is dropped.
- Latency: a request that first appears in cycle n, with the arbiter in IDLE, gives `gnt_valid_o`=1 in cycle n+1.
- Back-to-back: a handshake in cycle n with other requests pending gives a new valid grant in cycle n+1, with no bubble. Sustained throughput is one grant per cycle when `gnt_ready_i` is held at 1.
- Outputs are driven directly from flops; there is no combinational path from inputs to outputs.

## Structure
- Shared package `arb_pkg`:
  - `NUM_REQ_DEF`=16 and `BIN_W_DEF`=4.
  - State enum `arb_state_e` {IDLE, GRANT}.
  - Typedef `gnt_idx_t` = `logic [BIN_W_DEF-1:0]`.
- Sub-module `rr_pick`: purely combinational rotated priority encoder.
  - Inputs: `req`, `ptr`.
  - Outputs: `found`, `idx`.
  - Implement it as two masked priority encodes (i ≥ `ptr` first, then all bits).
- The top level holds only the FSM, the pointer register and the output registers.

## Test plan
- Reset then single request: `req_i`=16'h0001, `gnt_ready_i`=1 → `gnt_valid_o`=1 one cycle later with `gnt_bin_o`=0. Release the request → IDLE; the pointer is now 1.
- Rotation: `req_i`=16'h8421 held, `gnt_ready_i`=1 → consecutive grants 0, 5, 10, 15, 0, … with `gnt_valid_o` continuously 1.
- Wrap-around: pointer at 15 (last grant 14) with `req_i`=16'hC003 → the next grants are 15, then 0, then 1.
- Backpressure hold: grant 3 issued, `gnt_ready_i`=0 for 5 cycles while `req_i` changes to 16'h0100 → `gnt_bin_o` stays 3. Raise ready → the next grant is 8.
- Reset mid-grant: `reset`=1 while `gnt_valid_o`=1 with grant 7 → the next cycle `gnt_valid_o`=0 and `gnt_bin_o`=0. After reset, with `req_i`=16'h0081, the grant is 0 (pointer back at 0).
- Integration: connect `gnt_bin_o` to the binary-to-one-hot decoder, run 32 random `req_i` vectors with random ready. Check that the decoder output is exactly `1<<gnt_bin_o`, that the index is never starved beyond `NUM_REQ` accepted grants, and that the grant is stable under backpressure.
